// File: rtl/expr_pkg.sv
// Shared constants and state encodings for the expression-checker front end.
// Imported by expr_checker and expr_stream_ctrl.
package expr_pkg;

    localparam logic [7:0] TERM_DEFAULT = 8'h0A;
    localparam int unsigned MAXLEN_DEFAULT = 64;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_LPAR  = 8'h28;
    localparam logic [7:0] CH_RPAR  = 8'h29;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FEED   = 2'd1,
        ST_REPORT = 2'd2
    } ctrl_state_t;

    typedef enum logic [2:0] {
        CK_EMPTY     = 3'd0,
        CK_BAD       = 3'd1,
        CK_OK        = 3'd2,
        CK_OP        = 3'd3,
        CK_PAR_EMPTY = 3'd4,
        CK_PAR_F     = 3'd5,
        CK_PAR_OP    = 3'd6
    } chk_state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

    function automatic logic is_op(input logic [7:0] c);
        return (c == CH_PLUS) || (c == CH_STAR);
    endfunction

endpackage

// File: rtl/expr_checker.sv
// Byte-serial recognizer for single-digit expressions with one level of parentheses.
// out is high when the bytes consumed since the last start form a complete legal expression.
module expr_checker
    import expr_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       en,
    input  logic [7:0] in,
    output logic       out
);

    chk_state_t state_q, state_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= CK_EMPTY;
        else     state_q <= state_d;
    end

    // BAD is absorbing; every unexpected byte lands there.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = CK_EMPTY;
        end else begin
            case (state_q)
                CK_EMPTY, CK_OP: if (en) begin
                    if (is_digit(in))       state_d = CK_OK;
                    else if (in == CH_LPAR) state_d = CK_PAR_EMPTY;
                    else                    state_d = CK_BAD;
                end
                CK_OK: if (en) begin
                    if (is_op(in)) state_d = CK_OP;
                    else           state_d = CK_BAD;
                end
                CK_PAR_EMPTY, CK_PAR_OP: if (en) begin
                    if (is_digit(in)) state_d = CK_PAR_F;
                    else              state_d = CK_BAD;
                end
                CK_PAR_F: if (en) begin
                    if (is_op(in))          state_d = CK_PAR_OP;
                    else if (in == CH_RPAR) state_d = CK_OK;
                    else                    state_d = CK_BAD;
                end
                CK_BAD:  state_d = CK_BAD;
                default: state_d = CK_BAD;
            endcase
        end
    end

    assign out = (state_q == CK_OK);

endmodule

// File: rtl/expr_stream_ctrl.sv
// Round-robin front end: grants one newline-terminated string at a time to the checker
// and returns one verdict per string on a valid/ready result port.
module expr_stream_ctrl
    import expr_pkg::*;
#(
    parameter logic [7:0]  TERM   = TERM_DEFAULT,
    parameter int unsigned MAXLEN = MAXLEN_DEFAULT
)(
    input  logic       clk,
    input  logic       clr,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_id,
    output logic       res_ok,
    output logic [6:0] res_len,
    output logic       busy
);

    // Handshakes: a byte or verdict moves on a rising edge where valid and ready are both high;
    // ready never depends on valid, and res_* stay stable while res_valid waits for res_ready.

    localparam logic [6:0] MAX_LEN7 = 7'(MAXLEN);
    localparam logic [6:0] LEN_SAT  = 7'h7F;

    ctrl_state_t state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        gnt_q, gnt_d;
    logic [6:0]  len_q, len_d;
    logic        res_id_d, res_ok_d;
    logic [6:0]  res_len_d;
    logic        feed_ready;
    logic        chk_start, chk_en, chk_out;
    logic        g_valid;
    logic [7:0]  g_data;

    assign g_valid = gnt_q ? req1_valid : req0_valid;
    assign g_data  = gnt_q ? req1_data  : req0_data;

    expr_checker u_checker (
        .clk   (clk),
        .clr   (clr),
        .start (chk_start),
        .en    (chk_en),
        .in    (g_data),
        .out   (chk_out)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            len_q   <= '0;
            res_id  <= 1'b0;
            res_ok  <= 1'b0;
            res_len <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            len_q   <= len_d;
            res_id  <= res_id_d;
            res_ok  <= res_ok_d;
            res_len <= res_len_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        len_d      = len_q;
        res_id_d   = res_id;
        res_ok_d   = res_ok;
        res_len_d  = res_len;
        feed_ready = 1'b0;
        chk_start  = 1'b0;
        chk_en     = 1'b0;
        case (state_q)
            ST_IDLE: if (req0_valid || req1_valid) begin
                // Pointer's source wins if it is asking, otherwise the other one.
                gnt_d     = ptr_q ? req1_valid : !req0_valid;
                ptr_d     = !gnt_d;
                chk_start = 1'b1;
                len_d     = '0;
                state_d   = ST_FEED;
            end
            ST_FEED: begin
                feed_ready = 1'b1;
                if (g_valid) begin
                    if (g_data == TERM) begin
                        res_ok_d  = chk_out && (len_q != '0) && (len_q <= MAX_LEN7);
                        res_len_d = len_q;
                        res_id_d  = gnt_q;
                        state_d   = ST_REPORT;
                    end else begin
                        chk_en = 1'b1;
                        if (len_q != LEN_SAT) len_d = len_q + 7'd1;
                    end
                end
            end
            ST_REPORT: if (res_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign req0_ready = feed_ready && !gnt_q;
    assign req1_ready = feed_ready &&  gnt_q;
    assign res_valid  = (state_q == ST_REPORT);
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_expr_stream_ctrl.sv
// Directed bench for expr_stream_ctrl with a string-level legality model and per-source
// expected-verdict queues checked on every result-port cycle.
module tb_expr_stream_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       res_valid, res_ready, res_id, res_ok, busy;
    logic [6:0] res_len;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         id_log[$];
    logic       last_id, last_ok;
    logic [6:0] last_len;

    expr_stream_ctrl dut (
        .clk        (clk),
        .clr        (clr),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_ok     (res_ok),
        .res_len    (res_len),
        .busy       (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic bit is_d(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic bit model_ok(input string s);
        int n;
        int i;
        logic [7:0] c;
        n = s.len();
        i = 0;
        if (n == 0 || n > 64) return 1'b0;
        while (1) begin
            if (i >= n) return 1'b0;
            c = s[i];
            if (is_d(c)) begin
                i++;
            end else if (c == 8'h28) begin
                i++;
                if (i >= n || !is_d(s[i])) return 1'b0;
                i++;
                while (i < n && (s[i] == 8'h2B || s[i] == 8'h2A)) begin
                    i++;
                    if (i >= n || !is_d(s[i])) return 1'b0;
                    i++;
                end
                if (i >= n || s[i] != 8'h29) return 1'b0;
                i++;
            end else begin
                return 1'b0;
            end
            if (i == n) return 1'b1;
            if (s[i] != 8'h2B && s[i] != 8'h2A) return 1'b0;
            i++;
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] model_verdict(input string s);
        int n;
        logic [6:0] l;
        n = s.len();
        l = (n > 127) ? 7'd127 : 7'(n);
        return {model_ok(s), l};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_valid(input int src, input logic v);
        if (src == 0) req0_valid = v; else req1_valid = v;
    endtask

    task automatic set_data(input int src, input logic [7:0] d);
        if (src == 0) req0_data = d; else req1_data = d;
    endtask

    function automatic logic get_ready(input int src);
        return (src == 0) ? req0_ready : req1_ready;
    endfunction

    task automatic send(input int src, input string body, input bit term, output int first_wait);
        int n;
        int w;
        logic [7:0] b;
        first_wait = -1;
        if (term) begin
            if (src == 0) exp_q0.push_back(model_verdict(body));
            else          exp_q1.push_back(model_verdict(body));
        end
        n = body.len() + (term ? 1 : 0);
        @(negedge clk);
        set_valid(src, 1'b1);
        for (int i = 0; i < n; i++) begin
            b = (i < body.len()) ? body[i] : 8'h0A;
            set_data(src, b);
            w = 0;
            while (!get_ready(src) && w < 400) begin
                @(negedge clk);
                w++;
            end
            if (i == 0) first_wait = w;
            if (w >= 400) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout src %0d byte %0d: got ready 0 expected 1", src, i);
                break;
            end
            @(negedge clk);
        end
        set_valid(src, 1'b0);
    endtask

    task automatic set_res_ready(input logic v);
        @(posedge clk);
        #2 res_ready = v;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || res_valid) && w < 100) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 100) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q0.size() + exp_q1.size());
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!clr && res_valid) begin
            check("no_ready_in_report", {30'd0, req1_ready, req0_ready}, 32'd0);
            if ((res_id ? exp_q1.size() : exp_q0.size()) == 0) begin
                checks++;
                errors++;
                $display("FAIL stale_verdict: got id %0d ok %0d len %0d expected none", res_id, res_ok, res_len);
            end else begin
                check(res_id ? "verdict_src1" : "verdict_src0", {24'd0, res_ok, res_len},
                      {24'd0, res_id ? exp_q1[0] : exp_q0[0]});
                if (res_ready) begin
                    if (res_id) void'(exp_q1.pop_front());
                    else        void'(exp_q0.pop_front());
                    id_log.push_back(int'(res_id));
                    last_id  = res_id;
                    last_ok  = res_ok;
                    last_len = res_len;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int w0, w1;
        string s;
        clr = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00;
        res_ready = 1'b1;
        #3;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        check("rst_res", {23'd0, res_id, res_ok, res_len}, 32'd0);

        // model pins
        check("model_legal_paren", {31'd0, model_ok("1+(2*3)")}, 32'd1);
        check("model_nested", {31'd0, model_ok("((1)")}, 32'd0);
        check("model_empty", {31'd0, model_ok("")}, 32'd0);
        check("model_dangling_op", {31'd0, model_ok("8*")}, 32'd0);
        check("model_verdict_7", {24'd0, model_verdict("1+(2*3)")}, 32'h87);

        @(negedge clk);
        clr = 1'b0;

        // contention straight out of reset alternates 0,1,0,1
        fork
            begin send(0, "5", 1, w0); send(0, "9", 1, w0); end
            begin send(1, "(4", 1, w1); send(1, "8*8", 1, w1); end
        join
        drain();
        check("rr_count", id_log.size(), 4);
        if (id_log.size() == 4) begin
            check("rr_order", {id_log[0][7:0], id_log[1][7:0], id_log[2][7:0], id_log[3][7:0]},
                  32'h00010001);
        end
        check("rr_last", {23'd0, last_id, last_ok, last_len}, {23'd0, 1'b1, 1'b1, 7'd3});

        // single string, grant latency and verdict timing
        send(0, "1+(2*3)", 1, w0);
        check("grant_latency", w0, 1);
        check("verdict_next_cycle", {31'd0, res_valid}, 32'd1);
        drain();
        check("t1_verdict", {23'd0, last_id, last_ok, last_len}, {23'd0, 1'b0, 1'b1, 7'd7});

        send(1, "((1)", 1, w1);
        drain();
        check("nested_verdict", {23'd0, last_id, last_ok, last_len}, {23'd0, 1'b1, 1'b0, 7'd4});
        send(1, "", 1, w1);
        drain();
        check("empty_verdict", {23'd0, last_id, last_ok, last_len}, {23'd0, 1'b1, 1'b0, 7'd0});

        // 65-byte legal-looking string and 200-byte saturating string
        s = "1";
        for (int i = 0; i < 32; i++) s = {s, "+1"};
        send(0, s, 1, w0);
        drain();
        check("len65_verdict", {23'd0, last_id, last_ok, last_len}, {23'd0, 1'b0, 1'b0, 7'd65});
        s = "";
        for (int i = 0; i < 100; i++) s = {s, "1+"};
        send(0, s, 1, w0);
        drain();
        check("len200_verdict", {23'd0, last_id, last_ok, last_len}, {23'd0, 1'b0, 1'b0, 7'd127});

        // consumer stalls in REPORT
        set_res_ready(1'b0);
        send(1, "2", 1, w1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, res_valid}, 32'd1);
            check("stall_busy", {31'd0, busy}, 32'd1);
        end
        set_res_ready(1'b1);
        set_res_ready(1'b0);
        @(negedge clk);
        check("pulse_to_idle", {30'd0, res_valid, busy}, 32'd0);
        check("stall_verdict", {23'd0, last_id, last_ok, last_len}, {23'd0, 1'b1, 1'b1, 7'd1});
        set_res_ready(1'b1);

        // asynchronous clear in the middle of a string
        send(0, "3*(", 0, w0);
        check("mid_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #3 clr = 1'b1;
        #1;
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        check("clr_res", {22'd0, res_valid, res_id, res_ok, res_len}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        send(0, "7", 1, w0);
        drain();
        check("post_clr_verdict", {23'd0, last_id, last_ok, last_len}, {23'd0, 1'b0, 1'b1, 7'd1});

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/expr_stream_ctrl.md
# expr_stream_ctrl

Two-requester front end for the single-digit expression checker. It arbitrates round-robin between two byte-stream sources and grants one whole newline-terminated string at a time. It restarts the checker, feeds it the granted bytes and returns one verdict per string on a valid/ready result port. It sits between the character sources (UART/test feeders) and the verdict consumer.

## Interface
- TERM, 8'h0A, string terminator byte; consumed, never fed to the checker
- MAXLEN, 64, longest legal string in bytes, terminator excluded; longer strings are forced illegal
- clk  in  1  clock, all state on rising edge
- clr  in  1  reset, asynchronous, active-high
- req0_valid  in  1  source 0 byte valid
- req0_data  in  8  source 0 byte
- req0_ready  out  1  source 0 byte accepted when valid&ready
- req1_valid / req1_data / req1_ready  same as source 0, for source 1
- res_valid  out  1  verdict available
- res_ready  in  1  consumer accepts verdict
- res_id  out  1  source that produced the verdict
- res_ok  out  1  1 = legal expression
- res_len  out  7  bytes before terminator, saturating at 127
- busy  out  1  FSM not in IDLE

## Operation
- Grammar (checker): operand = digit '0'..'9' or '(' digit {('+'|'*') digit} ')'; expr = operand {('+'|'*') operand}. No nested parentheses. Any other byte makes the string permanently illegal.
- FSM states: IDLE, FEED, REPORT.
- IDLE: if any req*_valid, grant the source chosen by the round-robin pointer (pointer's source if valid, else the other); pulse chk_start for one cycle; go to FEED. The pointer then favours the non-granted source. Reset pointer favours source 0.
- FEED: only the granted ready = 1. On accepted non-TERM byte: chk_en = 1 with that byte; len += 1 (saturating at 127). On accepted TERM: capture ok = chk_out & (len != 0) & (len <= MAXLEN); go to REPORT.
- REPORT: res_valid = 1, outputs stable; on res_ready go to IDLE.
- Non-granted source: ready = 0 always; its valid/data may change freely and are ignored.
- Reset values: FSM IDLE, all ready 0, res_valid 0, res_id 0, res_ok 0, res_len 0, busy 0, pointer = 0.
- clr mid-string: everything returns to reset values immediately; the partial string is dropped and no verdict is issued.

## Timing
- Grant latency: valid seen in IDLE cycle t -> ready high in cycle t+1; the first byte is accepted at the end of t+1 at the earliest.
- Throughput in FEED: 1 byte/cycle. chk_out reflects all bytes accepted up to the previous edge, so sampling at TERM acceptance is exact.
- Verdict: TERM accepted at edge e -> res_valid high from e+1 until the res_ready edge.
- Minimum string cost: 1 (IDLE) + n+1 (FEED) + 1 (REPORT) cycles with res_ready held high.
- Both valid in the same IDLE cycle: the pointer source wins; back-to-back contention alternates 0,1,0,1.
- Empty string (TERM first): res_ok = 0, res_len = 0.

## Structure
- Shared package expr_pkg: TERM default, ASCII constants ('0', '9', '+', '*', '(', ')'), FSM state encoding.
- Sub-module expr_checker (ports clk, clr, start, en, in[7:0], out): recognizer FSM with states EMPTY, BAD, OK, OP, PAR_EMPTY, PAR_F, PAR_OP. out = (state == OK).
  - start has priority over en and returns the checker to EMPTY.
  - When en = 0 the checker holds its state.
  - Unused state encodings go to BAD.
- Controller holds the arbiter pointer, FSM, length counter and result registers.

## Test plan
- Source 0 sends "1+(2*3)\n", res_ready = 1 -> res_valid with id 0, ok 1, len 7; res_valid appears 1 cycle after TERM acceptance.
- Both sources valid at once after reset, strings "5\n" and "(4\n" -> first id 0 ok 1 len 1, then id 1 ok 0 len 2.
- Source 1 sends "((1)\n" -> ok 0 len 4. Source 1 sends "\n" -> ok 0 len 0.
- A 65-byte legal string "1+1+...+1" (MAXLEN 64) -> ok 0 len 65. A 200-byte string -> len saturates at 127, ok 0.
- res_ready held 0 for 5 cycles in REPORT -> outputs stable, both ready 0; res_ready pulse -> IDLE next edge.
- clr asserted mid-string "3*(" -> all outputs reset asynchronously; a following "7\n" from source 0 -> ok 1 len 1, with no stale verdict issued.
